// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode constants, canonical NOP and
// the fetch FSM state type used by the fetch stage and its testbench.
package riscv_pkg;

   localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface fetch_stage_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC select for the fetch stage: flush target, taken
// branch target or sequential pc+4, with redirect targets word-aligned.
module fetch_stage_pc_next #(
   parameter int XLEN = 32
)(
   input  logic [XLEN-1:0] pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_target,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] flush_pc
);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));

   always_comb begin
      flush_pc = flush_target & ALIGN_MASK;
      if (flush) begin
         next_pc = flush_pc;
      end else if (branch_taken) begin
         next_pc = branch_target & ALIGN_MASK;
      end else begin
         // sequential path wraps naturally at 2^XLEN
         next_pc = pc + XLEN'(3'd4);
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// holds each fetched word stable for decode until it is consumed or flushed.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              rst,
   fetch_stage_if.master     imem,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   input  logic              flush,
   input  logic [XLEN-1:0]   flush_target,
   output logic [31:0]       instr,
   output logic [6:0]        opcode,
   output logic [XLEN-1:0]   pc,
   output logic              instr_valid
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            req_q, req_d;
   logic            rdy_s;
   logic [XLEN-1:0] next_pc_s;
   logic [XLEN-1:0] flush_pc_s;

   fetch_stage_pc_next #(.XLEN(XLEN)) u_pc_next (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .flush         (flush),
      .flush_target  (flush_target),
      .next_pc       (next_pc_s),
      .flush_pc      (flush_pc_s)
   );

   // A ready only counts while our request is actually on the bus.
   assign rdy_s = imem.imem_ready & req_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      instr_d = instr_q;
      valid_d = valid_q;
      case (state_q)
         FETCH: begin
            if (flush) begin
               if (rdy_s || !req_q) begin
                  pc_d = flush_pc_s;
               end else begin
                  pend_d  = flush_pc_s;
                  state_d = DRAIN;
               end
            end else if (rdy_s) begin
               instr_d = imem.imem_rdata;
               valid_d = 1'b1;
               state_d = ISSUE;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            // the stale request must complete before the redirect is fetched
            if (rdy_s) begin
               pc_d    = flush ? flush_pc_s : pend_q;
               state_d = FETCH;
            end else if (flush) begin
               pend_d = flush_pc_s;
            end else begin
               state_d = DRAIN;
            end
         end
         ISSUE: begin
            if (flush || !stall) begin
               valid_d = 1'b0;
               pc_d    = next_pc_s;
               state_d = FETCH;
            end else begin
               state_d = ISSUE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = FETCH;
         end
      endcase
      req_d = (state_d != ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         pend_q  <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign opcode         = instr_q[6:0];
   assign pc             = pc_q;
   assign instr_valid    = valid_q;
endmodule
